// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM states, command opcodes and halt causes.
package core_run_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_STEPPING   = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    OP_HALT       = 2'd0,
    OP_RUN        = 2'd1,
    OP_STEP       = 2'd2,
    OP_CORE_RESET = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    HC_NONE = 2'd0,
    HC_CMD  = 2'd1,
    HC_STEP = 2'd2,
    HC_BP   = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Command handshake between a debug host (master) and the run controller (slave).
interface core_run_ctrl_if #(
  parameter int STEP_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/core_run_ctrl_bp_match.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
module bp_match #(
  parameter int NUM_BP = 2,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 1
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [PC_W-1:0]  addr_i [NUM_BP],
  input  logic [NUM_BP-1:0] en_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (en_i[i] && (addr_i[i] == pc_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step controller for a debug-attached core: gates the core clock enable,
// holds core reset, matches PC breakpoints and exposes a registered probe mux.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int NUM_BP   = 2,
  parameter int STEP_W   = 16,
  parameter int RST_CYC  = 4,
  parameter int PROBE_CH = 4,
  parameter int PROBE_W  = 32,
  localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int PSEL_W   = (PROBE_CH > 1) ? $clog2(PROBE_CH) : 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  core_run_ctrl_if.slave              cmd,
  input  logic                        bp_wr,
  input  logic [BP_IDX_W-1:0]         bp_idx,
  input  logic [PC_W-1:0]             bp_addr,
  input  logic                        bp_en,
  input  logic [PC_W-1:0]             core_pc,
  output logic                        core_ce,
  output logic                        core_rst,
  input  logic [PROBE_CH*PROBE_W-1:0] probe_in,
  input  logic [PSEL_W-1:0]           probe_sel,
  output logic [PROBE_W-1:0]          probe_out,
  output logic [1:0]                  state_o,
  output logic [1:0]                  halt_cause,
  output logic [BP_IDX_W-1:0]         bp_hit_idx,
  output logic                        cmd_err
);

  localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
  logic                mask_q, mask_d;
  halt_cause_e         haltCause_q, haltCause_d;
  logic [BP_IDX_W-1:0] hitIdx_q, hitIdx_d;
  logic                cmdErr_q, cmdErr_d;
  logic [PC_W-1:0]     bpAddr_q [NUM_BP];
  logic [NUM_BP-1:0]   bpEn_q;
  logic [PROBE_W-1:0]  probe_q;

  logic                bpHitRaw, bpHit, cmdAccept, ceInt;
  logic [BP_IDX_W-1:0] bpIdx;
  cmd_op_e             op;

  bp_match #(.NUM_BP(NUM_BP), .PC_W(PC_W), .IDX_W(BP_IDX_W)) u_bp_match (
    .pc_i   (core_pc),
    .addr_i (bpAddr_q),
    .en_i   (bpEn_q),
    .hit_o  (bpHitRaw),
    .idx_o  (bpIdx)
  );

  assign op            = cmd_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (state_q != ST_RESET_HOLD);
  assign cmdAccept     = cmd.cmd_valid && (state_q != ST_RESET_HOLD);
  // The first cycle after a resume ignores matches so the core can leave a breakpoint PC.
  assign bpHit         = bpHitRaw && !mask_q;

  always_comb begin
    state_d     = state_q;
    holdCnt_d   = holdCnt_q;
    stepCnt_d   = stepCnt_q;
    mask_d      = 1'b0;
    haltCause_d = haltCause_q;
    hitIdx_d    = hitIdx_q;
    cmdErr_d    = 1'b0;
    ceInt       = 1'b0;
    case (state_q)
      ST_RESET_HOLD: begin
        if (holdCnt_q == HOLD_W'(RST_CYC - 1)) begin
          state_d   = ST_HALTED;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmdAccept) begin
          case (op)
            OP_RUN: begin
              state_d = ST_RUNNING;
              mask_d  = 1'b1;
            end
            OP_STEP: begin
              state_d   = ST_STEPPING;
              mask_d    = 1'b1;
              stepCnt_d = (cmd.cmd_arg == '0) ? STEP_W'(1) : cmd.cmd_arg;
            end
            OP_CORE_RESET: begin
              state_d     = ST_RESET_HOLD;
              holdCnt_d   = '0;
              haltCause_d = HC_NONE;
            end
            default: ;
          endcase
        end
      end
      default: begin
        ceInt = !bpHit;
        if (cmdAccept && (op != OP_HALT)) cmdErr_d = 1'b1;
        // Breakpoint beats step completion, which beats a host HALT.
        if (bpHit) begin
          state_d     = ST_HALTED;
          haltCause_d = HC_BP;
          hitIdx_d    = bpIdx;
        end else if ((state_q == ST_STEPPING) && (stepCnt_q == STEP_W'(1))) begin
          state_d     = ST_HALTED;
          haltCause_d = HC_STEP;
          stepCnt_d   = '0;
        end else begin
          if (state_q == ST_STEPPING) stepCnt_d = stepCnt_q - 1'b1;
          if (cmdAccept && (op == OP_HALT)) begin
            state_d     = ST_HALTED;
            haltCause_d = HC_CMD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_RESET_HOLD;
      holdCnt_q   <= '0;
      stepCnt_q   <= '0;
      mask_q      <= 1'b0;
      haltCause_q <= HC_NONE;
      hitIdx_q    <= '0;
      cmdErr_q    <= 1'b0;
      bpAddr_q    <= '{default: '0};
      bpEn_q      <= '0;
      probe_q     <= '0;
    end else begin
      state_q     <= state_d;
      holdCnt_q   <= holdCnt_d;
      stepCnt_q   <= stepCnt_d;
      mask_q      <= mask_d;
      haltCause_q <= haltCause_d;
      hitIdx_q    <= hitIdx_d;
      cmdErr_q    <= cmdErr_d;
      if (bp_wr && (int'(bp_idx) < NUM_BP)) begin
        bpAddr_q[bp_idx] <= bp_addr;
        bpEn_q[bp_idx]   <= bp_en;
      end
      if (state_q == ST_HALTED) probe_q <= probe_in[int'(probe_sel)*PROBE_W +: PROBE_W];
    end
  end

  assign core_ce    = ceInt;
  assign core_rst   = (state_q == ST_RESET_HOLD);
  assign probe_out  = probe_q;
  assign state_o    = state_q;
  assign halt_cause = haltCause_q;
  assign bp_hit_idx = hitIdx_q;
  assign cmd_err    = cmdErr_q;

endmodule
